// File: rtl/divider_pkg.sv
// Shared types and helpers for the signed iterative divider.
package divider_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned MAX_WIDTH = 128;
  localparam int unsigned MAX_IDX_W = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_e;

  // Absolute value of the low w bits of x. The caller truncates the result to w bits.
  function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] x,
                                                   input int unsigned w);
    return x[MAX_IDX_W'(w - 1)] ? -x : x;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the divider and its client.
interface divider_if #(parameter int unsigned WIDTH = divider_pkg::WIDTH_DEF) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             div_by_zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (output start, a, b,
                  input  div_by_zero, busy, done, quotient, remainder);
  modport slave  (input  start, a, b,
                  output div_by_zero, busy, done, quotient, remainder);
endinterface

// File: rtl/divider_unsigned_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per step, MSB first.
module divider_unsigned_core #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  // quo_q starts as the dividend and fills with quotient bits as dividend bits shift out
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last_c    = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/divider.sv
// Signed divider top: handshake, sign capture, RISC-V special cases and sign fix-up.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  divider_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             b_zero_q, b_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             core_load_c;
  logic             core_step_c;
  logic             core_last_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [WIDTH-1:0] core_quot;
  logic [WIDTH-1:0] core_rem;

  assign abs_a_c = WIDTH'(abs_val(MAX_WIDTH'(a_q), WIDTH));
  assign abs_b_c = WIDTH'(abs_val(MAX_WIDTH'(b_q), WIDTH));

  divider_unsigned_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (core_load_c),
    .step      (core_step_c),
    .dividend  (abs_a_c),
    .divisor   (abs_b_c),
    .quotient  (core_quot),
    .remainder (core_rem),
    .last_c    (core_last_c)
  );

  // busy_q stays high in the done cycle, which also blocks a start presented alongside done
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    b_zero_d    = b_zero_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    core_load_c = 1'b0;
    core_step_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !busy_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = LOAD;
        end
      end
      LOAD: begin
        core_load_c = 1'b1;
        q_neg_d     = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        r_neg_d     = a_q[WIDTH-1];
        b_zero_d    = (b_q == '0);
        state_d     = ITER;
      end
      ITER: begin
        core_step_c = 1'b1;
        if (core_last_c) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        dbz_d   = b_zero_q;
        state_d = IDLE;
        if (b_zero_q) begin
          quot_d = '1;
          rem_d  = a_q;
        end else begin
          quot_d = q_neg_q ? -core_quot : core_quot;
          rem_d  = r_neg_q ? -core_rem  : core_rem;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      b_zero_q <= b_zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;

endmodule

// File: tb/tb_divider.sv
// Directed and randomized checks of the signed divider at WIDTH=64.
module tb_divider;

  localparam int unsigned W   = 64;
  localparam int          LAT = 66;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  divider_if #(.WIDTH(W)) bus ();
  divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [W-1:0] absu(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  // Present one request in the current cycle; return at the done cycle (or after a bound).
  task automatic do_div(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    lat = 0;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[$];
    int   lat;
    tbl.push_back('{a: 64'd8,    b: 64'd4,    q: 64'd2,    r: 64'd0,    z: 1'b0});
    tbl.push_back('{a: 64'd12,   b: -64'sd3,  q: -64'sd4,  r: 64'd0,    z: 1'b0});
    tbl.push_back('{a: -64'sd12, b: 64'd3,    q: -64'sd4,  r: 64'd0,    z: 1'b0});
    tbl.push_back('{a: -64'sd12, b: -64'sd3,  q: 64'd4,    r: 64'd0,    z: 1'b0});
    tbl.push_back('{a: -64'sd7,  b: 64'd2,    q: -64'sd3,  r: -64'sd1,  z: 1'b0});
    tbl.push_back('{a: 64'd7,    b: -64'sd2,  q: -64'sd3,  r: 64'd1,    z: 1'b0});
    tbl.push_back('{a: 64'd0,    b: 64'd5,    q: 64'd0,    r: 64'd0,    z: 1'b0});
    tbl.push_back('{a: 64'd5,    b: 64'd0,    q: 64'hFFFF_FFFF_FFFF_FFFF, r: 64'd5, z: 1'b1});
    tbl.push_back('{a: -64'sd7,  b: 64'd0,    q: 64'hFFFF_FFFF_FFFF_FFFF, r: -64'sd7, z: 1'b1});
    tbl.push_back('{a: 64'h8000_0000_0000_0000, b: -64'sd1, q: 64'h8000_0000_0000_0000, r: 64'd0, z: 1'b0});
    tbl.push_back('{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h8000_0000_0000_0000, q: 64'd0,
                    r: 64'h7FFF_FFFF_FFFF_FFFF, z: 1'b0});
    foreach (tbl[i]) begin
      do_div(tbl[i].a, tbl[i].b, lat);
      vectors++;
      if (lat !== LAT) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT);
      end
      vectors++;
      if (bus.quotient !== tbl[i].q || bus.remainder !== tbl[i].r || bus.div_by_zero !== tbl[i].z) begin
        miscompares++;
        $display("FAIL dir%0d_result: q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", i,
                 bus.quotient, bus.remainder, bus.div_by_zero, tbl[i].q, tbl[i].r, tbl[i].z);
      end
      vectors++;
      if (bus.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL dir%0d_busy_at_done: got %b want 1", i, bus.busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== tbl[i].q) begin
        miscompares++;
        $display("FAIL dir%0d_after_done: done=%b busy=%b q=%h want 0 0 %h", i,
                 bus.done, bus.busy, bus.quotient, tbl[i].q);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_div(64'd8, 64'd3, lat);
    vectors++;
    if (lat !== LAT || bus.quotient !== 64'd2 || bus.remainder !== 64'd2) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d q=%h r=%h want %0d 2 2", lat, bus.quotient, bus.remainder, LAT);
    end
    @(posedge clk); #1;
    do_div(64'd64, 64'd4, lat);
    vectors++;
    if (lat !== LAT || bus.quotient !== 64'd16 || bus.remainder !== 64'd0) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d q=%h r=%h want %0d 16 0", lat, bus.quotient, bus.remainder, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    int lat;
    int seen;
    bus.start = 1'b1; bus.a = 64'd100; bus.b = 64'd7;
    @(posedge clk); #1;
    bus.a = 64'd1; bus.b = 64'd1;
    repeat (10) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    lat = 10;
    while (!bus.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++;
    if (lat !== LAT || bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin
      miscompares++;
      $display("FAIL busy_start_result: lat=%0d q=%h r=%h want %0d 14 2", lat, bus.quotient, bus.remainder, LAT);
    end
    // start alongside done must be ignored
    bus.start = 1'b1; bus.a = 64'd9; bus.b = 64'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_with_done: busy=%b want 0", bus.busy);
    end
    seen = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    vectors++;
    if (seen !== 0 || bus.quotient !== 64'd14) begin
      miscompares++;
      $display("FAIL start_with_done_hold: dones=%0d q=%h want 0 and 14", seen, bus.quotient);
    end
  endtask

  task automatic test_abort();
    int seen;
    int lat;
    bus.start = 1'b1; bus.a = 64'd100; bus.b = 64'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%b done=%b dbz=%b q=%h r=%h want all zero",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    seen = 0;
    repeat (LAT + 10) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done: %0d active cycles want 0", seen);
    end
    do_div(-64'sd100, 64'd7, lat);
    vectors++;
    if (lat !== LAT || bus.quotient !== -64'sd14 || bus.remainder !== -64'sd2) begin
      miscompares++;
      $display("FAIL abort_recover: lat=%0d q=%h r=%h want %0d -14 -2", lat, bus.quotient, bus.remainder, LAT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, eq, er, prod;
    longint       sa, sb;
    logic         ez, inv_ok;
    int           lat;
    for (int n = 0; n < 1000; n++) begin
      av = {$urandom, $urandom} >> $urandom_range(0, 63);
      bv = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) av = -av;
      if ($urandom_range(0, 3) == 0) bv = -bv;
      if (n % 100 == 7) bv = '0;
      sa = av; sb = bv;
      ez = 1'b0;
      if (bv == '0) begin
        eq = '1; er = av; ez = 1'b1;
      end else if (av == 64'h8000_0000_0000_0000 && bv == '1) begin
        eq = av; er = '0;
      end else begin
        eq = sa / sb; er = sa % sb;
      end
      do_div(av, bv, lat);
      vectors++;
      if (lat !== LAT || bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ez) begin
        miscompares++;
        $display("FAIL rand%0d: a=%h b=%h lat=%0d q=%h r=%h dbz=%b want q=%h r=%h dbz=%b", n, av, bv,
                 lat, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, ez);
      end
      if (bv != '0) begin
        prod   = bus.quotient * bv + bus.remainder;
        inv_ok = (prod == av) && (absu(bus.remainder) < absu(bv)) &&
                 (bus.remainder == '0 || bus.remainder[W-1] == av[W-1]);
        vectors++;
        if (inv_ok !== 1'b1) begin
          miscompares++;
          $display("FAIL rand%0d_invariant: a=%h b=%h q=%h r=%h", n, av, bv, bus.quotient, bus.remainder);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_back_to_back();
    test_busy_start();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
